imm_alu_sequencer: RTL and testbench

Parametrised multi-cycle execute unit for the 8-bit datapath: accepts one ALU instruction per start handshake, reads operands from an internal register file, computes through an ALU sub-module, writes back, and updates zero/carry flags. Generalises the single-register immediate sequencer to N registers, a configurable data width, register-register and immediate modes, a start/done handshake and illegal-opcode reporting. It sits between instruction decode and the register/flag state of the core.

---
 rtl/imm_alu_sequencer_pkg.sv | 67 ++++++
 rtl/imm_alu_sequencer_alu_core.sv | 46 ++++
 rtl/imm_alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_imm_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_alu_sequencer_pkg.sv
// Shared encodings for the immediate/register ALU sequencer: opcodes,
// ALU modes, FSM states and the opcode decoder.
package imm_alu_sequencer_pkg;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MR  = 4'h2;
  localparam logic [3:0] OP_MI  = 4'h3;
  localparam logic [3:0] OP_SUM = 4'h4;
  localparam logic [3:0] OP_SMI = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h6;
  localparam logic [3:0] OP_SBI = 4'h7;
  localparam logic [3:0] OP_ANR = 4'h8;
  localparam logic [3:0] OP_ANI = 4'h9;
  localparam logic [3:0] OP_ORR = 4'hA;
  localparam logic [3:0] OP_ORI = 4'hB;
  localparam logic [3:0] OP_XRR = 4'hC;
  localparam logic [3:0] OP_XRI = 4'hD;
  localparam logic [3:0] OP_CM  = 4'hE;
  localparam logic [3:0] OP_CMI = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_CMP, ALU_PASS_B
  } alu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_READ, ST_EXEC, ST_WRITE
  } state_e;

  typedef struct packed {
    logic      legal;
    logic      use_imm;
    logic      writes;
    logic      sets_flags;
    alu_mode_e mode;
  } op_ctl_t;

  // Every immediate-form opcode has bit 0 set; register forms have it clear.
  function automatic op_ctl_t decode_op(input logic [3:0] op);
    op_ctl_t c;
    c.legal      = 1'b1;
    c.use_imm    = op[0];
    c.writes     = 1'b1;
    c.sets_flags = 1'b1;
    c.mode       = ALU_PASS_B;
    case (op)
      OP_LD, OP_ST: begin
        c.legal      = 1'b0;
        c.writes     = 1'b0;
        c.sets_flags = 1'b0;
      end
      OP_MR, OP_MI:   c.sets_flags = 1'b0;
      OP_SUM, OP_SMI: c.mode = ALU_ADD;
      OP_SB, OP_SBI:  c.mode = ALU_SUB;
      OP_ANR, OP_ANI: c.mode = ALU_AND;
      OP_ORR, OP_ORI: c.mode = ALU_OR;
      OP_XRR, OP_XRI: c.mode = ALU_XOR;
      OP_CM, OP_CMI: begin
        c.mode   = ALU_CMP;
        c.writes = 1'b0;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_alu_sequencer_alu_core.sv
// Combinational ALU: add/sub/compare with carry-borrow, bitwise logic,
// pass-through of B; zero reflects the DATA_W-bit result.
module alu_core
  import imm_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        mode,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] ext;

  // Compute result and carry for the selected mode.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path can
    // leave a value unassigned and infer a latch.
    ext   = '0;
    y     = '0;
    carry = 1'b0;
    case (alu_mode_e'(mode))
      ALU_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      // The extra top bit of the widened difference is the borrow (a < b).
      ALU_SUB, ALU_CMP: begin
        ext   = {1'b0, a} - {1'b0, b};
        y     = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/imm_alu_sequencer.sv
// Multi-cycle execute unit: IDLE -> READ -> EXEC -> WRITE, with a small
// register file, zero/carry flags and illegal-opcode reporting. WRITE
// accepts a new start directly so back-to-back issue runs at 3 cycles each.
module imm_alu_sequencer
  import imm_alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] imm,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              carry_flag,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [DATA_W-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d, carry_q, carry_d;
  logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  op_ctl_t           ctl;
  logic [DATA_W-1:0] alu_y;
  logic              alu_carry, alu_zero;

  assign ctl = decode_op(op_q);

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .mode  (ctl.mode),
    .y     (alu_y),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // Next-state, operand, result, flag and register-file update logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    regs_d    = regs_q;
    case (state_q)
      ST_READ: begin
        a_d     = regs_q[rd_q];
        b_d     = ctl.use_imm ? imm_q : regs_q[rs_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ctl.legal) result_d = alu_y;
        if (ctl.sets_flags) begin
          zero_d  = alu_zero;
          carry_d = alu_carry;
        end
        done_d    = 1'b1;
        illegal_d = ~ctl.legal;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (ctl.writes) regs_d[rd_q] = result_q;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
    // Capture a new instruction from IDLE, or straight out of WRITE.
    if ((state_q == ST_IDLE || state_q == ST_WRITE) && start) begin
      op_d    = opcode;
      rd_d    = rd;
      rs_d    = rs;
      imm_d   = imm;
      state_d = ST_READ;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // All state, including the register file, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      // NOTE: the register file is architecturally visible state that must
      // read 0 after reset, so it is built from resettable flops, not a RAM.
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign result     = result_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Self-checking bench: directed cases plus random instructions checked
// against an arithmetic reference model; second instance at 16 bits/8 regs.
module tb_imm_alu_sequencer;
  import imm_alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit, 4-register instance
  logic       start, busy, done, illegal, zero_flag, carry_flag;
  logic [3:0] opcode;
  logic [1:0] rd, rs, dbg_addr;
  logic [7:0] imm, result, dbg_data;

  // 16-bit, 8-register instance
  logic        start_w, busy_w, done_w, illegal_w, zero_w, carry_w;
  logic [3:0]  opcode_w;
  logic [2:0]  rd_w, rs_w, dbg_addr_w;
  logic [15:0] imm_w, result_w, dbg_data_w;

  imm_alu_sequencer #(.DATA_W(8), .NREG(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rd(rd), .rs(rs),
    .imm(imm), .busy(busy), .done(done), .illegal(illegal), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  imm_alu_sequencer #(.DATA_W(16), .NREG(8)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .opcode(opcode_w), .rd(rd_w),
    .rs(rs_w), .imm(imm_w), .busy(busy_w), .done(done_w),
    .illegal(illegal_w), .result(result_w), .zero_flag(zero_w),
    .carry_flag(carry_w), .dbg_addr(dbg_addr_w), .dbg_data(dbg_data_w)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for the 8-bit instance.
  int mreg [4];
  int mres, mz, mc;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mres = 0; mz = 0; mc = 0;
  endtask

  // Architectural effect of one instruction, from the instruction-set rules.
  task automatic model_apply(input logic [3:0] op, input int d, input int s,
                             input int im, output bit ill);
    int a, b;
    ill = 1'b0;
    a = mreg[d];
    b = (op inside {OP_MI, OP_SMI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_CMI})
        ? im : mreg[s];
    case (op)
      OP_MR, OP_MI: begin mres = b; mreg[d] = b; end
      OP_SUM, OP_SMI: begin
        mc = (a + b > 255) ? 1 : 0;
        mres = (a + b) % 256; mz = (mres == 0) ? 1 : 0; mreg[d] = mres;
      end
      OP_SB, OP_SBI: begin
        mc = (a < b) ? 1 : 0;
        mres = (a - b + 256) % 256; mz = (mres == 0) ? 1 : 0; mreg[d] = mres;
      end
      OP_CM, OP_CMI: begin
        mc = (a < b) ? 1 : 0;
        mres = (a - b + 256) % 256; mz = (a == b) ? 1 : 0;
      end
      OP_ANR, OP_ANI: begin
        mres = a & b; mc = 0; mz = (mres == 0) ? 1 : 0; mreg[d] = mres;
      end
      OP_ORR, OP_ORI: begin
        mres = a | b; mc = 0; mz = (mres == 0) ? 1 : 0; mreg[d] = mres;
      end
      OP_XRR, OP_XRI: begin
        mres = a ^ b; mc = 0; mz = (mres == 0) ? 1 : 0; mreg[d] = mres;
      end
      default: ill = 1'b1;
    endcase
  endtask

  // Compare registers, flags and result against the model (call at negedge).
  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(mreg[i]));
    end
    check({tag, "_zero"}, 32'(zero_flag), 32'(mz));
    check({tag, "_carry"}, 32'(carry_flag), 32'(mc));
    check({tag, "_result"}, 32'(result), 32'(mres));
  endtask

  // Issue one instruction and check the handshake cycle by cycle.
  task automatic issue(input logic [3:0] op, input logic [1:0] d,
                       input logic [1:0] s, input logic [7:0] im,
                       input string tag);
    bit ill;
    @(negedge clk);
    start = 1'b1; opcode = op; rd = d; rs = s; imm = im;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; opcode = 4'($urandom); rd = 2'($urandom);
    rs = 2'($urandom); imm = 8'($urandom);
    check({tag, "_busy_read"}, 32'(busy), 32'd1);
    check({tag, "_done_read"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_done_exec"}, 32'(done), 32'd0);
    @(negedge clk);
    model_apply(op, int'(d), int'(s), int'(im), ill);
    check({tag, "_done_write"}, 32'(done), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'(ill));
    @(negedge clk);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check_state(tag);
  endtask

  task automatic issue_w(input logic [3:0] op, input logic [2:0] d,
                         input logic [2:0] s, input logic [15:0] im);
    @(negedge clk);
    start_w = 1'b1; opcode_w = op; rd_w = d; rs_w = s; imm_w = im;
    @(negedge clk);
    start_w = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int dones;
    start = 1'b0; opcode = '0; rd = '0; rs = '0; imm = '0; dbg_addr = '0;
    start_w = 1'b0; opcode_w = '0; rd_w = '0; rs_w = '0; imm_w = '0;
    dbg_addr_w = '0;
    model_reset();

    // Reset state
    rst = 1'b1;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;

    // Immediate add without carry
    issue(OP_MI, 2'd0, 2'd0, 8'h29, "mi_r0");
    issue(OP_SMI, 2'd0, 2'd0, 8'h07, "smi_r0");
    check("smi_r0_value", 32'(result), 32'h30);

    // Register add with carry out
    issue(OP_MI, 2'd1, 2'd0, 8'hF0, "mi_r1");
    issue(OP_MI, 2'd2, 2'd0, 8'h20, "mi_r2");
    issue(OP_SUM, 2'd1, 2'd2, 8'h00, "sum_r1r2");
    check("sum_carry", 32'(carry_flag), 32'd1);

    // Subtract to zero, then compare with borrow
    issue(OP_MI, 2'd0, 2'd0, 8'h05, "mi_r0b");
    issue(OP_SBI, 2'd0, 2'd0, 8'h05, "sbi_zero");
    check("sbi_zero_flag", 32'(zero_flag), 32'd1);
    issue(OP_CMI, 2'd0, 2'd0, 8'h01, "cmi_borrow");
    check("cmi_borrow_flag", 32'(carry_flag), 32'd1);

    // Logic ops against 0x29 with 0x0F
    issue(OP_MI, 2'd3, 2'd0, 8'h29, "mi_r3");
    issue(OP_ANI, 2'd3, 2'd0, 8'h0F, "ani");
    check("ani_value", 32'(result), 32'h09);
    issue(OP_MI, 2'd3, 2'd0, 8'h29, "mi_r3b");
    issue(OP_ORI, 2'd3, 2'd0, 8'h0F, "ori");
    check("ori_value", 32'(result), 32'h2F);
    issue(OP_MI, 2'd3, 2'd0, 8'h29, "mi_r3c");
    issue(OP_XRI, 2'd3, 2'd0, 8'h0F, "xri");
    check("xri_value", 32'(result), 32'h26);

    // rd == rs, register move, illegal opcodes
    issue(OP_SUM, 2'd1, 2'd1, 8'h00, "sum_self");
    issue(OP_MR, 2'd2, 2'd3, 8'h00, "mr");
    issue(OP_LD, 2'd1, 2'd2, 8'h55, "ld_illegal");
    issue(OP_ST, 2'd2, 2'd1, 8'hAA, "st_illegal");

    // Start held high: one instruction per three cycles
    @(negedge clk);
    start = 1'b1; opcode = OP_SMI; rd = 2'd3; rs = 2'd0; imm = 8'h01;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (i == 0) check("b2b_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd4);
    for (int i = 0; i < 4; i++) begin
      bit ill;
      model_apply(OP_SMI, 3, 0, 1, ill);
    end
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    check_state("b2b");

    // Randomized instructions
    for (int n = 0; n < 40; n++)
      issue(4'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
            $sformatf("rnd%0d", n));

    // Reset asserted during EXEC of SMI
    @(negedge clk);
    start = 1'b1; opcode = OP_SMI; rd = 2'd0; rs = 2'd0; imm = 8'h11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_in_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_state("post_rst");

    // Wide instance: 0xFFF0 + 0x0020 and the top register
    issue_w(OP_MI, 3'd1, 3'd0, 16'hFFF0);
    issue_w(OP_MI, 3'd2, 3'd0, 16'h0020);
    issue_w(OP_SUM, 3'd1, 3'd2, 16'h0000);
    dbg_addr_w = 3'd1;
    #1;
    check("w_sum_r1", 32'(dbg_data_w), 32'h0010);
    check("w_sum_carry", 32'(carry_w), 32'd1);
    check("w_sum_zero", 32'(zero_w), 32'd0);
    issue_w(OP_MI, 3'd7, 3'd0, 16'h1234);
    dbg_addr_w = 3'd7;
    #1;
    check("w_r7", 32'(dbg_data_w), 32'h1234);
    check("w_r7_flags_kept", 32'(carry_w), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
